// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser, counter debounce and a
// registered single-cycle advance pulse with optional hold-to-repeat.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 20,
  parameter int REPEAT_PERIOD   = 8,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic button
);

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    REPEAT
  } state_e;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  state_e           state_q, state_d;
  logic             button_q, button_d;

  always_comb begin
    level_d = level_q;
    dcnt_d  = '0;
    if (s2_q != level_q) begin
      if (dcnt_q == DB_LAST) begin
        level_d = s2_q;
      end else begin
        dcnt_d = dcnt_q + ONE;
      end
    end
  end

  // Release outranks repeat_en, which outranks a due repeat pulse.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    button_d = 1'b0;
    case (state_q)
      IDLE: begin
        rcnt_d = '0;
        if (level_q) begin
          state_d  = HELD;
          button_d = 1'b1;
        end
      end
      HELD: begin
        if (!level_q) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (!repeat_en) begin
          rcnt_d = '0;
        end else if (rcnt_q == RD_LAST) begin
          state_d  = REPEAT;
          button_d = 1'b1;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + ONE;
        end
      end
      REPEAT: begin
        if (!level_q) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (!repeat_en) begin
          state_d = HELD;
          rcnt_d  = '0;
        end else if (rcnt_q == RP_LAST) begin
          button_d = 1'b1;
          rcnt_d   = '0;
        end else begin
          rcnt_d = rcnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      level_q  <= 1'b0;
      dcnt_q   <= '0;
      rcnt_q   <= '0;
      state_q  <= IDLE;
      button_q <= 1'b0;
    end else begin
      s1_q     <= btn_raw;
      s2_q     <= s1_q;
      level_q  <= level_d;
      dcnt_q   <= dcnt_d;
      rcnt_q   <= rcnt_d;
      state_q  <= state_d;
      button_q <= button_d;
    end
  end

  assign btn_level = level_q;
  assign button    = button_q;

endmodule
